// File: rtl/mult_8x8_seq_ctrl_if.sv
// Operand/result handshake and shared 4x4 core port of the 8x8 sequential multiplier.
// The slave modport is the sequencer's view; master is the environment (producer, consumer, core).
interface mult_8x8_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_r;
  logic        mul_en;
  logic [1:0]  mul_q;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic [7:0]  mul_r;

  modport slave (
    input  in_valid, in_a, in_b, out_ready, mul_r,
    output in_ready, out_valid, out_r, mul_en, mul_q, mul_a, mul_b
  );

  modport master (
    output in_valid, in_a, in_b, out_ready, mul_r,
    input  in_ready, out_valid, out_r, mul_en, mul_q, mul_a, mul_b
  );
endinterface

// File: rtl/mult_8x8_seq_ctrl.sv
// Builds an 8x8 product from one shared 4x4 core over four quadrant cycles (LL, LH, HL, HH),
// merging shifted partials by OR (COMBINE=0) or exact add (COMBINE=1), then holds the result.
module mult_8x8_seq_ctrl #(
  parameter bit COMBINE   = 1'b0,
  parameter bit LL_ONLY_N = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  output logic                     busy,
  mult_8x8_seq_ctrl_if.slave       bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_Q0,
    S_Q1,
    S_Q2,
    S_Q3,
    S_DONE
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  op_a, op_b;
  logic [15:0] acc, acc_nx, out_r_q;
  logic [15:0] partial;
  logic [1:0]  quad;
  logic        active;
  logic        accept;

  // NOTE: every signal written here gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_nx = state;
    active   = 1'b0;
    quad     = 2'd0;
    unique case (state)
      S_IDLE: if (bus.in_valid) state_nx = S_Q0;
      S_Q0:   begin active = 1'b1; quad = 2'd0; state_nx = S_Q1;   end
      S_Q1:   begin active = 1'b1; quad = 2'd1; state_nx = S_Q2;   end
      S_Q2:   begin active = 1'b1; quad = 2'd2; state_nx = S_Q3;   end
      S_Q3:   begin active = 1'b1; quad = 2'd3; state_nx = S_DONE; end
      S_DONE: if (bus.out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  // quad[1] selects the A nibble, quad[0] the B nibble; idle cycles drive zeros to keep the core quiet.
  always_comb begin
    bus.mul_en = active;
    bus.mul_q  = LL_ONLY_N ? 2'd0 : quad;
    bus.mul_a  = 4'd0;
    bus.mul_b  = 4'd0;
    if (active) begin
      bus.mul_a = quad[1] ? op_a[7:4] : op_a[3:0];
      bus.mul_b = quad[0] ? op_b[7:4] : op_b[3:0];
    end
  end

  always_comb begin
    partial = {8'b0, bus.mul_r};
    unique case (quad)
      2'd0:       partial = {8'b0, bus.mul_r};
      2'd1, 2'd2: partial = {8'b0, bus.mul_r} << 4;
      2'd3:       partial = {8'b0, bus.mul_r} << 8;
      default:    partial = {8'b0, bus.mul_r};
    endcase
    acc_nx = COMBINE ? (acc + partial) : (acc | partial);
  end

  assign accept = (state == S_IDLE) && bus.in_valid && !flush;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_a    <= 8'd0;
      op_b    <= 8'd0;
      acc     <= 16'd0;
      out_r_q <= 16'd0;
    end else begin
      state <= state_nx;
      if (flush) begin
        acc <= 16'd0;
      end else if (accept) begin
        op_a <= bus.in_a;
        op_b <= bus.in_b;
        acc  <= 16'd0;
      end else if (active) begin
        acc <= acc_nx;
      end
      // The result register only moves on the Q3->DONE edge; a flush leaves the last product visible.
      if (!flush && state == S_Q3) out_r_q <= acc_nx;
    end
  end

  assign bus.in_ready  = (state == S_IDLE) && !flush;
  assign bus.out_valid = (state == S_DONE);
  assign bus.out_r     = out_r_q;
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Directed bench: two sequencers (OR merge and exact add) run in lockstep against an exact 4x4 core.
module tb_mult_8x8_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_a, in_b;
  logic       out_ready;
  logic       busy0, busy1;

  int n_cmp = 0;
  int n_err = 0;

  mult_8x8_seq_ctrl_if if0 ();
  mult_8x8_seq_ctrl_if if1 ();

  assign if0.in_valid  = in_valid;
  assign if0.in_a      = in_a;
  assign if0.in_b      = in_b;
  assign if0.out_ready = out_ready;
  assign if0.mul_r     = {4'b0, if0.mul_a} * {4'b0, if0.mul_b};
  assign if1.in_valid  = in_valid;
  assign if1.in_a      = in_a;
  assign if1.in_b      = in_b;
  assign if1.out_ready = out_ready;
  assign if1.mul_r     = {4'b0, if1.mul_a} * {4'b0, if1.mul_b};

  mult_8x8_seq_ctrl #(.COMBINE(1'b0), .LL_ONLY_N(1'b0)) dut_or (
    .clk(clk), .rst_n(rst_n), .flush(flush), .busy(busy0), .bus(if0)
  );
  mult_8x8_seq_ctrl #(.COMBINE(1'b1), .LL_ONLY_N(1'b0)) dut_add (
    .clk(clk), .rst_n(rst_n), .flush(flush), .busy(busy1), .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] r_or;
    logic [15:0] r_add;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // One full operation with timing, quadrant and (optional) backpressure checks.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp_or, input logic [15:0] exp_add, input int hold);
    logic [7:0]  qseq;
    logic        nib_ok;
    logic        bp_ok;
    logic [1:0]  eq;
    logic [15:0] r0, r1;
    int          cyc;
    @(negedge clk);
    check("in_ready_idle", {if0.in_ready, if1.in_ready}, 2'b11);
    in_valid = 1'b1; in_a = a; in_b = b;
    @(negedge clk);
    cyc = 1;
    in_valid = 1'b0; in_a = ~a; in_b = b ^ 8'h5A;
    qseq = 8'd0; nib_ok = 1'b1;
    while (!if0.out_valid && cyc < 20) begin
      eq = 2'(cyc - 1);
      qseq = {if0.mul_q, qseq[7:2]};
      if (!(if0.mul_en && if1.mul_en && if1.mul_q == eq &&
            if0.mul_a == (eq[1] ? a[7:4] : a[3:0]) && if0.mul_b == (eq[0] ? b[7:4] : b[3:0]) &&
            if1.mul_a == if0.mul_a && if1.mul_b == if0.mul_b))
        nib_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check("out_valid", {if0.out_valid, if1.out_valid}, 2'b11);
    check("latency", cyc, 5);
    check("mul_q_seq", qseq, 8'hE4);
    check("nibbles", nib_ok, 1'b1);
    check("quiet_done", {if0.mul_en, if0.mul_a, if0.mul_b, if1.mul_en, if1.mul_a, if1.mul_b}, 0);
    check("out_r_or", if0.out_r, exp_or);
    check("out_r_add", if1.out_r, exp_add);
    r0 = if0.out_r; r1 = if1.out_r;
    if (hold > 0) begin
      bp_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!(if0.out_valid && if1.out_valid && !if0.in_ready && !if1.in_ready &&
              if0.out_r == r0 && if1.out_r == r1))
          bp_ok = 1'b0;
      end
      check("backpressure_hold", bp_ok, 1'b1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("release_idle", {if0.out_valid, if1.out_valid, if0.in_ready, if1.in_ready}, 4'b0011);
  endtask

  initial begin
    vecs[0] = '{8'hFF, 8'hFF, 16'hEFF1, 16'hFE01};
    vecs[1] = '{8'h11, 8'h11, 16'h0111, 16'h0121};
    vecs[2] = '{8'h03, 8'h07, 16'h0015, 16'h0015};
    vecs[3] = '{8'h80, 8'h02, 16'h0100, 16'h0100};
    vecs[4] = '{8'h00, 8'hFF, 16'h0000, 16'h0000};
    vecs[5] = '{8'h0F, 8'hF0, 16'h0E10, 16'h0E10};
    vecs[6] = '{8'h12, 8'h34, 16'h0368, 16'h03A8};
    vecs[7] = '{8'hA5, 8'h5A, 16'h37F2, 16'h3A02};
    vecs[8] = '{8'hFF, 8'h01, 16'h00FF, 16'h00FF};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; out_ready = 1'b0;
    #1;
    check("reset_ready", {if0.in_ready, if1.in_ready, if0.out_valid, if1.out_valid, busy0, busy1}, 6'b110000);
    check("reset_out_r", {if0.out_r, if1.out_r}, 32'd0);
    check("reset_core", {if0.mul_en, if0.mul_q, if0.mul_a, if0.mul_b}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].r_or, vecs[i].r_add, 0);

    // Ten cycles of backpressure after DONE.
    do_op(8'h12, 8'h34, 16'h0368, 16'h03A8, 10);

    // out_ready and in_valid together in DONE: return to IDLE without accepting.
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'h0F; in_b = 8'hF0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !if0.out_valid; i++) @(negedge clk);
    check("done_reached", {if0.out_valid, if1.out_valid}, 2'b11);
    in_valid = 1'b1; in_a = 8'h33; in_b = 8'h33; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    #1;
    check("no_accept_on_release", {busy0, busy1}, 2'b00);
    check("prev_result", {if0.out_r, if1.out_r}, {16'h0E10, 16'h0E10});

    // Flush in Q2 discards the operation and keeps the previous out_r.
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'h5A; in_b = 8'hC3;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("q2_before_flush", {if0.mul_en, if0.mul_q}, 3'b110);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_idle", {busy0, busy1, if0.out_valid, if1.out_valid, if0.in_ready, if1.in_ready}, 6'b000011);
    check("flush_keeps_out_r", {if0.out_r, if1.out_r}, {16'h0E10, 16'h0E10});
    do_op(8'h03, 8'h07, 16'h0015, 16'h0015, 0);

    // Flush in IDLE blocks acceptance.
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_a = 8'h09; in_b = 8'h09;
    #1;
    check("flush_ready_low", {if0.in_ready, if1.in_ready}, 2'b00);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_idle_no_accept", {busy0, busy1}, 2'b00);

    // Asynchronous reset in Q1.
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("q1_before_reset", {if0.mul_en, if0.mul_q}, 3'b101);
    #2 rst_n = 1'b0;
    #1;
    check("arst_flags", {if0.in_ready, if1.in_ready, if0.out_valid, if1.out_valid, busy0, busy1}, 6'b110000);
    check("arst_out_r", {if0.out_r, if1.out_r}, 32'd0);
    check("arst_core", {if0.mul_en, if0.mul_q, if0.mul_a, if0.mul_b, if1.mul_en, if1.mul_a, if1.mul_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h80, 8'h02, 16'h0100, 16'h0100, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
